// File: rtl/apu_pkg.sv
// Shared step positions and mode type for the APU frame sequencer.
package apu_pkg;

    localparam int unsigned STEP_Q1     = 7457;
    localparam int unsigned STEP_QH2    = 14913;
    localparam int unsigned STEP_Q3     = 22371;
    localparam int unsigned STEP_4_IRQ  = 29828;
    localparam int unsigned STEP_4_LAST = 29829;
    localparam int unsigned STEP_5_LAST = 37281;

    typedef enum logic {
        MODE_4STEP = 1'b0,
        MODE_5STEP = 1'b1
    } apu_mode_t;

endpackage

// File: rtl/apu_frame_step_decode.sv
// Combinational step decoder: maps the current step count and mode to
// quarter/half-frame events, the IRQ-set condition and end-of-sequence.
module apu_frame_step_decode
    import apu_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic [CNT_W-1:0] count,
    input  apu_mode_t        mode,
    output logic             q,
    output logic             h,
    output logic             irq_set,
    output logic             last
);

    always_comb begin
        q       = 1'b0;
        h       = 1'b0;
        irq_set = 1'b0;
        last    = 1'b0;
        if (count == CNT_W'(STEP_Q1)) begin
            q = 1'b1;
        end
        if (count == CNT_W'(STEP_QH2)) begin
            q = 1'b1;
            h = 1'b1;
        end
        if (count == CNT_W'(STEP_Q3)) begin
            q = 1'b1;
        end
        if (mode == MODE_4STEP) begin
            if (count == CNT_W'(STEP_4_IRQ)) begin
                irq_set = 1'b1;
            end
            if (count == CNT_W'(STEP_4_LAST)) begin
                q       = 1'b1;
                h       = 1'b1;
                irq_set = 1'b1;
                last    = 1'b1;
            end
        end else if (count == CNT_W'(STEP_5_LAST)) begin
            q    = 1'b1;
            h    = 1'b1;
            last = 1'b1;
        end
    end

endmodule

// File: rtl/apu_frame_counter.sv
// APU frame sequencer ($4017): quarter/half-frame strobes and frame IRQ.
// Define APU_FRAME_IRQ_EN to build the IRQ flag, inhibit bit and $4015 clear.
module apu_frame_counter
    import apu_pkg::*;
#(
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned WR_DELAY = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cpu_ce,
    input  logic       reg_wr,
    input  logic [7:0] reg_wdata,
    input  logic       status_rd,
    output logic       quarter_frame,
    output logic       half_frame,
    output logic       frame_irq,
    output logic       mode_5step
);

    logic [CNT_W-1:0] count;
    apu_mode_t        mode;
    logic             pending;
    logic [2:0]       delay;
    logic             dec_q, dec_h, dec_irq_set, dec_last;
    logic             reload_tick;

    apu_frame_step_decode #(.CNT_W(CNT_W)) u_decode (
        .count   (count),
        .mode    (mode),
        .q       (dec_q),
        .h       (dec_h),
        .irq_set (dec_irq_set),
        .last    (dec_last)
    );

    // A write in the same clk restarts the delay, so it blocks the reload.
    assign reload_tick = cpu_ce && pending && !reg_wr && (delay == 3'd1);
    assign mode_5step  = (mode == MODE_5STEP);

    always_ff @(posedge clk) begin
        if (reset) begin
            count         <= '0;
            mode          <= MODE_4STEP;
            pending       <= 1'b0;
            delay         <= '0;
            quarter_frame <= 1'b0;
            half_frame    <= 1'b0;
        end else begin
            quarter_frame <= 1'b0;
            half_frame    <= 1'b0;
            if (cpu_ce) begin
                if (reload_tick) begin
                    count   <= '0;
                    pending <= 1'b0;
                    if (mode == MODE_5STEP) begin
                        quarter_frame <= 1'b1;
                        half_frame    <= 1'b1;
                    end
                end else begin
                    quarter_frame <= dec_q;
                    half_frame    <= dec_h;
                    count         <= dec_last ? '0 : count + CNT_W'(1);
                    if (pending && !reg_wr) begin
                        delay <= delay - 3'd1;
                    end
                end
            end
            if (reg_wr) begin
                mode    <= apu_mode_t'(reg_wdata[7]);
                pending <= 1'b1;
                delay   <= 3'(WR_DELAY);
            end
        end
    end

`ifdef APU_FRAME_IRQ_EN
    logic inhibit;
    logic irq_flag;
    logic irq_set_tick;
    logic unused_wdata;

    assign irq_set_tick = cpu_ce && !reload_tick && dec_irq_set && !inhibit;
    assign unused_wdata = &{1'b0, reg_wdata[5:0]};

    // Inhibit write beats a same-clk set; a set beats a same-clk status read.
    always_ff @(posedge clk) begin
        if (reset) begin
            inhibit  <= 1'b0;
            irq_flag <= 1'b0;
        end else begin
            if (reg_wr) begin
                inhibit <= reg_wdata[6];
            end
            if (reg_wr && reg_wdata[6]) begin
                irq_flag <= 1'b0;
            end else if (irq_set_tick) begin
                irq_flag <= 1'b1;
            end else if (status_rd) begin
                irq_flag <= 1'b0;
            end
        end
    end

    assign frame_irq = irq_flag;
`else
    logic unused_irq;

    assign unused_irq = &{1'b0, reg_wdata[6:0], status_rd, dec_irq_set};
    assign frame_irq  = 1'b0;
`endif

endmodule

// File: tb/tb_apu_frame_counter.sv
// Scoreboard bench for apu_frame_counter against a step-table reference model.
module tb_apu_frame_counter;

`ifdef APU_FRAME_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif
    localparam int WR_DELAY = 3;

    logic       clk;
    logic       reset;
    logic       cpu_ce;
    logic       reg_wr;
    logic [7:0] reg_wdata;
    logic       status_rd;
    logic       quarter_frame;
    logic       half_frame;
    logic       frame_irq;
    logic       mode_5step;

    apu_frame_counter #(.CNT_W(16), .WR_DELAY(WR_DELAY)) dut (
        .clk           (clk),
        .reset         (reset),
        .cpu_ce        (cpu_ce),
        .reg_wr        (reg_wr),
        .reg_wdata     (reg_wdata),
        .status_rd     (status_rd),
        .quarter_frame (quarter_frame),
        .half_frame    (half_frame),
        .frame_irq     (frame_irq),
        .mode_5step    (mode_5step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    typedef struct {
        int unsigned stamp;
        bit          q;
        bit          h;
    } pulse_t;

    pulse_t exp_q[$];
    int     checks   = 0;
    int     failures = 0;
    bit     armed    = 1'b0;
    bit     exp_irq  = 1'b0;
    bit     exp_mode = 1'b0;

    // Reference state: position in the frame, mode, inhibit, IRQ and the
    // number of CPU ticks still to go before a written reset takes effect.
    int m_cnt  = 0;
    bit m_mode = 1'b0;
    bit m_inh  = 1'b0;
    bit m_irq  = 1'b0;
    int m_left = 0;

    task automatic chk(input string name, input logic act, input logic expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %b expected %b (edge %0d)", name, act, expv, edge_n);
        end
    endtask

    task automatic model_edge(input bit rst, input bit ce, input bit wr,
                              input logic [7:0] wd, input bit rd);
        int period;
        bit q, h, set, nirq;
        q = 1'b0; h = 1'b0; set = 1'b0;
        if (rst) begin
            m_cnt = 0; m_mode = 1'b0; m_inh = 1'b0; m_irq = 1'b0; m_left = 0;
            return;
        end
        if (ce) begin
            if (m_left == 1 && !wr) begin
                m_cnt  = 0;
                m_left = 0;
                q = m_mode;
                h = m_mode;
            end else begin
                period = m_mode ? 37282 : 29830;
                q = (m_cnt == 7457) || (m_cnt == 14913) || (m_cnt == 22371) || (m_cnt == period - 1);
                h = (m_cnt == 14913) || (m_cnt == period - 1);
                set = IRQ_ON && !m_mode && !m_inh && (m_cnt == 29828 || m_cnt == 29829);
                m_cnt = (m_cnt == period - 1) ? 0 : (m_cnt + 1) % 65536;
                if (m_left > 1 && !wr) m_left--;
            end
        end
        nirq = m_irq;
        if (set) nirq = 1'b1;
        else if (rd) nirq = 1'b0;
        if (wr && wd[6]) nirq = 1'b0;
        m_irq = IRQ_ON ? nirq : 1'b0;
        if (wr) begin
            m_mode = wd[7];
            m_inh  = IRQ_ON ? wd[6] : 1'b0;
            m_left = WR_DELAY;
        end
        if (q || h) exp_q.push_back('{edge_n + 1, q, h});
    endtask

    task automatic tick(input bit rst, input bit ce, input bit wr,
                        input logic [7:0] wd, input bit rd);
        reset = rst; cpu_ce = ce; reg_wr = wr; reg_wdata = wd; status_rd = rd;
        model_edge(rst, ce, wr, wd, rd);
        @(posedge clk);
        exp_irq  = m_irq;
        exp_mode = m_mode;
        #1;
        reset = 1'b0; cpu_ce = 1'b0; reg_wr = 1'b0; status_rd = 1'b0;
    endtask

    // Monitor: compares strobes against the scoreboard and levels against the model.
    bit eq, eh;
    always @(negedge clk) begin
        if (armed) begin
            eq = 1'b0; eh = 1'b0;
            if (exp_q.size() > 0 && exp_q[0].stamp == edge_n) begin
                eq = exp_q[0].q;
                eh = exp_q[0].h;
                void'(exp_q.pop_front());
            end
            if (quarter_frame || half_frame || eq || eh) begin
                chk("quarter_frame", quarter_frame, eq);
                chk("half_frame", half_frame, eh);
            end
            chk("frame_irq", frame_irq, exp_irq);
            chk("mode_5step", mode_5step, exp_mode);
        end
    end

    initial begin
        reset = 1'b1; cpu_ce = 1'b0; reg_wr = 1'b0; reg_wdata = '0; status_rd = 1'b0;
        tick(1, 0, 0, 8'h00, 0);
        tick(1, 1, 0, 8'h00, 0);
        armed = 1'b1;
        chk("reset_qf", quarter_frame, 1'b0);
        chk("reset_irq", frame_irq, 1'b0);
        chk("reset_mode", mode_5step, 1'b0);

        // 4-step frame from reset, IRQ set/clear corner cases at its end
        for (int i = 0; i < 29828; i++) tick(0, 1, 0, 8'h00, 0);
        tick(0, 1, 0, 8'h00, 0);
        chk("irq_set_29828", frame_irq, IRQ_ON);
        tick(0, 0, 0, 8'h00, 1);
        chk("status_rd_clear", frame_irq, 1'b0);
        tick(0, 1, 0, 8'h00, 1);
        chk("set_beats_read", frame_irq, IRQ_ON);
        tick(0, 0, 1, 8'h40, 0);
        chk("inhibit_write_clear", frame_irq, 1'b0);
        for (int i = 0; i < 3; i++) tick(0, 1, 0, 8'h00, 0);
        for (int i = 0; i < 40; i++) tick(0, 1, 0, 8'h00, 1);
        chk("inhibit_holds", frame_irq, 1'b0);

        // 5-step: write coincides with cpu_ce, reset pulse 3 ticks later, full period
        tick(0, 1, 1, 8'h80, 0);
        chk("mode_latch_5", mode_5step, 1'b1);
        for (int i = 0; i < 3; i++) tick(0, 1, 0, 8'h00, 0);
        for (int i = 0; i < 37282 + 5; i++) tick(0, 1, 0, 8'h00, 0);
        chk("irq_5step_quiet", frame_irq, 1'b0);

        // cpu_ce held low after a write freezes everything
        tick(0, 0, 1, 8'h80, 0);
        for (int i = 0; i < 1000; i++) tick(0, 0, 0, 8'h00, 0);
        for (int i = 0; i < 4; i++) tick(0, 1, 0, 8'h00, 0);

        // reset cancels a write pending mid-delay
        tick(0, 0, 1, 8'h80, 0);
        tick(0, 1, 0, 8'h00, 0);
        tick(1, 0, 0, 8'h00, 0);
        chk("reset_mid_mode", mode_5step, 1'b0);
        for (int i = 0; i < 10; i++) tick(0, 1, 0, 8'h00, 0);

        // randomized traffic
        for (int i = 0; i < 9000; i++) begin
            tick($urandom_range(0, 4999) == 0,
                 $urandom_range(0, 9) < 7,
                 $urandom_range(0, 2999) == 0,
                 8'($urandom()),
                 $urandom_range(0, 19) == 0);
        end
        for (int i = 0; i < 4; i++) tick(0, 0, 0, 8'h00, 0);

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL pulses_outstanding: got %0d left expected 0", exp_q.size());
        end
        armed = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
